// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: fetch-PC sequencer. Owns the architectural PC, applies
// taken branch/jump resolutions, flushes wrong-path IF/ID work for
// FLUSH_CYCLES cycles and issues the JAL link-register write handshake.
// Optional feature macro: BRANCH_STATS_EN adds saturating resolution counters
// (stat_resolved_o, stat_taken_o).
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        resolve_valid,
  input  logic        resolve_taken,
  input  logic [31:0] resolve_target,
  input  logic        resolve_is_jal,
  input  logic [31:0] resolve_pc4,
  output logic        ex_stall_o,
  output logic [31:0] pc_o,
  output logic        fetch_valid_o,
  output logic        flush_o,
  output logic        lr_wr_req_o,
  output logic [31:0] lr_wr_data_o,
`ifdef BRANCH_STATS_EN
  output logic [31:0] stat_taken_o,
  output logic [31:0] stat_resolved_o,
`endif
  input  logic        lr_wr_ack_i
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HOLD,
    ST_FLUSH,
    ST_LR_WAIT
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] pc_inc;
  logic [31:0] target_aligned;
  logic [31:0] hold_target;
  logic        load_hold;
  logic [2:0]  flush_cnt;
  logic [2:0]  flush_cnt_nxt;
  logic        accept_any;
  logic        accept_taken;
  logic        accept_jal;
  logic        lr_done;

  // Instruction fetch is word aligned, so the low target bits are dropped.
  assign target_aligned = resolve_target & ~32'h3;
  assign pc_inc         = pc_o + 32'd4;

  // Resolutions are only consumed in RUN; elsewhere upstream is held off.
  assign accept_any   = (state == ST_RUN) && resolve_valid;
  assign accept_taken = accept_any && resolve_taken;
  assign accept_jal   = accept_taken && resolve_is_jal;
  assign lr_done      = lr_wr_req_o && lr_wr_ack_i;

  assign ex_stall_o = (state != ST_RUN);
  assign flush_o    = (state == ST_FLUSH);

  // Next-state, next-PC and flush-counter decode.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc_o;
    flush_cnt_nxt = flush_cnt;
    load_hold     = 1'b0;
    case (state)
      ST_RUN: begin
        if (resolve_valid && resolve_taken) begin
          if (stall_i) begin
            load_hold = 1'b1;
            state_nxt = ST_HOLD;
          end else begin
            pc_nxt        = target_aligned;
            flush_cnt_nxt = FLUSH_LOAD;
            state_nxt     = ST_FLUSH;
          end
        end else if (fetch_valid_o && !stall_i) begin
          pc_nxt = pc_inc;
        end
      end
      ST_HOLD: begin
        if (!stall_i) begin
          pc_nxt        = hold_target;
          flush_cnt_nxt = FLUSH_LOAD;
          state_nxt     = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (!stall_i) pc_nxt = pc_inc;
        // The counter keeps running even while fetch is stalled.
        if (flush_cnt <= 3'd1) begin
          flush_cnt_nxt = 3'd0;
          state_nxt     = (lr_wr_req_o && !lr_wr_ack_i) ? ST_LR_WAIT : ST_RUN;
        end else begin
          flush_cnt_nxt = flush_cnt - 3'd1;
        end
      end
      ST_LR_WAIT: begin
        if (!stall_i) pc_nxt = pc_inc;
        if (!lr_wr_req_o || lr_wr_ack_i) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Control state, PC and link-write handshake registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_RUN;
      pc_o          <= RESET_PC;
      fetch_valid_o <= 1'b0;
      flush_cnt     <= 3'd0;
      lr_wr_req_o   <= 1'b0;
      lr_wr_data_o  <= 32'd0;
    end else begin
      state         <= state_nxt;
      pc_o          <= pc_nxt;
      fetch_valid_o <= 1'b1;
      flush_cnt     <= flush_cnt_nxt;
      if (accept_jal) begin
        lr_wr_req_o  <= 1'b1;
        lr_wr_data_o <= resolve_pc4;
      end else if (lr_done) begin
        lr_wr_req_o <= 1'b0;
      end
    end
  end

  // Target captured while the redirect waits for the fetch stall to clear.
  always_ff @(posedge clk) begin
    if (load_hold) hold_target <= target_aligned;
  end

`ifdef BRANCH_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Saturating counters of accepted and accepted-taken resolutions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_resolved_o <= 32'd0;
      stat_taken_o    <= 32'd0;
    end else begin
      if (accept_any)   stat_resolved_o <= sat_inc(stat_resolved_o);
      if (accept_taken) stat_taken_o    <= sat_inc(stat_taken_o);
    end
  end
`endif

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Fetch-PC sequencer that owns the architectural PC register and applies branch/jump resolutions from the execute-stage Branch_Jump unit. On a taken redirect it steers the PC, flushes wrong-path IF/ID instructions for a fixed number of cycles, and issues a link-register write handshake for JAL. It sits between Branch_Jump (execute), the instruction-fetch stage and the register-file write arbiter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
FLUSH_CYCLES, 2, cycles flush_o stays high after a redirect (1..7).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset; all state is updated only on the rising edge of clk
stall_i  in  1  fetch stall; PC must not advance while high
resolve_valid  in  1  execute stage presents a resolved control-flow instruction
resolve_taken  in  1  redirect required (branch condition met, or any jump)
resolve_target  in  32  target PC from Branch_Jump
resolve_is_jal  in  1  instruction is JAL; link write required
resolve_pc4  in  32  PC+4 of the resolved instruction (link value)
ex_stall_o  out  1  execute must hold its resolution; high in any state other than RUN
pc_o  out  32  current fetch PC
fetch_valid_o  out  1  pc_o is valid for fetch
flush_o  out  1  invalidate IF/ID contents
lr_wr_req_o  out  1  link-register write request
lr_wr_data_o  out  32  link value
lr_wr_ack_i  in  1  register-file arbiter accepted the write

Behaviour:
- Reset (rst_n low at a clk edge):
  - State RUN; pc_o=RESET_PC.
  - fetch_valid_o, flush_o, lr_wr_req_o and ex_stall_o all 0; lr_wr_data_o=0.
  - fetch_valid_o goes to 1 on the first edge after rst_n is sampled high.
- Reset mid-operation: abandons any pending redirect, flush or link write. No lr_wr_req_o is re-issued.
- States:
  - RUN:
    - No accepted redirect and stall_i=0: pc_o <= pc_o+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
    - stall_i=1: pc_o holds.
    - resolve_valid && !resolve_taken: treated as ordinary sequential advance.
    - resolve_valid && resolve_taken && stall_i=0: pc_o <= {resolve_target[31:2],2'b00}; flush counter <= FLUSH_CYCLES; flush_o=1 next cycle; go to FLUSH.
    - Same condition with stall_i=1: latch target; go to HOLD.
  - HOLD: when stall_i falls, load the latched target and enter FLUSH exactly as above. flush_o=0 while in HOLD.
  - FLUSH:
    - flush_o=1; counter decrements each cycle.
    - PC advances by 4 per non-stalled cycle, starting from the target.
    - Exits to RUN when the counter reaches 0 and no link write is outstanding.
    - If the link write is outstanding at that point, go to LR_WAIT (flush_o=0).
  - LR_WAIT: PC continues sequentially; return to RUN on lr_wr_ack_i.
- JAL link write:
  - When a taken redirect with resolve_is_jal=1 is accepted (RUN or HOLD entry), lr_wr_data_o <= resolve_pc4 and lr_wr_req_o <= 1 at the same edge.
  - lr_wr_req_o and lr_wr_data_o are held stable until lr_wr_ack_i is sampled high while lr_wr_req_o=1. lr_wr_req_o drops on the following edge.
  - An ack sampled while lr_wr_req_o=0 is ignored.
- Resolution hold: ex_stall_o=1 in HOLD, FLUSH and LR_WAIT. resolve_valid is ignored in those states; upstream holds its resolution until ex_stall_o=0.
- Simultaneous events:
  - A redirect accepted in the same cycle as stall_i rising goes to HOLD.
  - stall_i during FLUSH freezes pc_o but the flush counter still decrements.
- Misaligned target: resolve_target[1:0] is forced to 0.

Optional Feature:
BRANCH_STATS_EN:
- Defined: adds outputs stat_taken_o[31:0] and stat_resolved_o[31:0].
  - stat_resolved_o increments on each accepted resolution (taken or not).
  - stat_taken_o increments on each accepted taken resolution.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=32'h100, stall_i=0 for 4 cycles -> pc_o 0x100, 0x100, 0x104, 0x108; fetch_valid_o=0 only during reset and the first cycle after.
- pc_o=0x200, taken resolution target=0x400, is_jal=0 -> pc_o=0x400 next cycle; flush_o high exactly 2 cycles; ex_stall_o high 2 cycles; lr_wr_req_o stays 0.
- JAL target=0x800, pc4=0x20C, lr_wr_ack_i delayed 5 cycles -> lr_wr_data_o=0x20C held with lr_wr_req_o high until ack; LR_WAIT entered after flush; RUN after ack.
- Taken redirect with stall_i=1 for 3 cycles -> pc_o frozen; flush_o=0 in HOLD; pc_o=target the cycle after stall_i falls.
- pc_o=32'hFFFF_FFFC, no redirect -> pc_o=0; target=0x403 -> pc_o=0x400.
- rst_n low during FLUSH with pending JAL write -> next cycle pc_o=RESET_PC, lr_wr_req_o=0, flush_o=0, state RUN.
